// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the MAC sequencer and its tag pipeline:
//   - FSM state encoding
//   - DSP slice OPMODE constants (multiply-clear / multiply-accumulate)
//   - DSP datapath widths (18x18 -> 36-bit product, 48-bit accumulator)
//   - per-operand tag that travels alongside the multiplier pipeline
// -----------------------------------------------------------------------------
package dsp_pkg;

   localparam int A_W = 18;
   localparam int B_W = 18;
   localparam int M_W = 36;
   localparam int P_W = 48;

   // X=M, Z=0 : P <= M        (first product of a job)
   localparam logic [7:0] OPM_MUL_CLR = 8'h01;
   // X=M, Z=P : P <= P + M    (every later product)
   localparam logic [7:0] OPM_MUL_ACC = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic valid;
      logic first;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   // Slice opcode for a product that is about to reach the post-adder.
   function automatic logic [7:0] opmode_for(input logic first);
      return first ? OPM_MUL_CLR : OPM_MUL_ACC;
   endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// -----------------------------------------------------------------------------
// dsp_tag_pipe
// Fixed-depth shift register that carries a small tag in lock-step with the
// DSP slice multiplier pipeline.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset (clears every stage)
//   adv_i   in   shift enable
//   tag_i   in   TAG_W tag entering stage 0
//   tag_o   out  TAG_W tag leaving the last stage
// -----------------------------------------------------------------------------
module dsp_tag_pipe #(
   parameter int DEPTH = 3,
   parameter int TAG_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             adv_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o
);

   logic [TAG_W-1:0] stage_q [DEPTH];

   // Shift stages when enabled; reset empties the whole pipe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= {TAG_W{1'b0}};
         end
      end else if (adv_i) begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Drives an external DSP slice to compute a signed dot product of `len`
// operand pairs. Operands stream in through a valid/ready handshake, are
// issued to the slice, and a tag pipeline matched to the multiplier latency
// decides when the post-adder loads (first product) or accumulates. The
// final P value is returned on a valid/ready result port.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   start, len                 job launch and pair count (sampled in IDLE)
//   busy                       job in progress until result handshake
//   op_valid/op_ready/op_a/b   operand-pair stream
//   dsp_A, dsp_B               operands to the slice
//   dsp_OPMODE, dsp_CE*        slice control
//   dsp_P                      slice accumulator output
//   res_valid/res_ready/data   result handshake
// All outputs are registered.
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
   import dsp_pkg::*;
#(
   parameter int M_LAT = 3,
   parameter int LEN_W = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [A_W-1:0]   op_a,
   input  logic [B_W-1:0]   op_b,
   output logic [A_W-1:0]   dsp_A,
   output logic [B_W-1:0]   dsp_B,
   output logic [7:0]       dsp_OPMODE,
   output logic             dsp_CEA,
   output logic             dsp_CEB,
   output logic             dsp_CEM,
   output logic             dsp_CEP,
   input  logic [P_W-1:0]   dsp_P,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [P_W-1:0]   res_data
);

   state_e           state_q,     state_d;
   logic [LEN_W-1:0] len_q,       len_d;
   logic [LEN_W-1:0] iss_cnt_q,   iss_cnt_d;
   logic [LEN_W-1:0] acc_cnt_q,   acc_cnt_d;
   logic             wait_q,      wait_d;
   logic [A_W-1:0]   dsp_a_q,     dsp_a_d;
   logic [B_W-1:0]   dsp_b_q,     dsp_b_d;
   logic             ce_q,        ce_d;
   logic             cep_q,       cep_d;
   logic [7:0]       opmode_q,    opmode_d;
   logic             op_ready_q,  op_ready_d;
   logic             busy_q,      busy_d;
   logic             res_valid_q, res_valid_d;
   logic [P_W-1:0]   res_data_q,  res_data_d;

   logic             adv_s;
   logic             accept_s;
   tag_t             tag_in_s;
   tag_t             tag_out_s;
   logic [TAG_W-1:0] tag_out_raw_s;

   // The slice pipeline and the tag pipe only move while a job is in flight.
   assign adv_s    = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   // op_ready_q can only be high in FEED, so no extra state qualifier needed.
   assign accept_s = op_valid & op_ready_q;

   assign tag_in_s.valid = accept_s;
   assign tag_in_s.first = accept_s && (iss_cnt_q == {LEN_W{1'b0}});
   assign tag_out_s      = tag_t'(tag_out_raw_s);

   // The tag leaves the pipe one cycle before its product reaches the
   // post-adder; the registered CEP/OPMODE below absorb that cycle.
   dsp_tag_pipe #(
      .DEPTH (M_LAT),
      .TAG_W (TAG_W)
   ) u_tag_pipe (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .adv_i  (adv_s),
      .tag_i  (tag_in_s),
      .tag_o  (tag_out_raw_s)
   );

   // Next-state and next-output computation for the job sequencer.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      iss_cnt_d  = iss_cnt_q;
      acc_cnt_d  = acc_cnt_q;
      wait_d     = wait_q;
      res_data_d = res_data_q;

      dsp_a_d = accept_s ? op_a : {A_W{1'b0}};
      dsp_b_d = accept_s ? op_b : {B_W{1'b0}};

      // Bubbles keep CEP low, so P is never disturbed by them.
      cep_d    = adv_s & tag_out_s.valid;
      opmode_d = cep_d ? opmode_for(tag_out_s.first) : OPM_MUL_ACC;

      if (cep_d) begin
         acc_cnt_d = acc_cnt_q + LEN_W'(1);
      end else begin
         acc_cnt_d = acc_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d      = len;
               iss_cnt_d  = {LEN_W{1'b0}};
               acc_cnt_d  = {LEN_W{1'b0}};
               wait_d     = 1'b0;
               res_data_d = {P_W{1'b0}};
               state_d    = (len == {LEN_W{1'b0}}) ? ST_DONE : ST_FEED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FEED: begin
            if (accept_s) begin
               iss_cnt_d = iss_cnt_q + LEN_W'(1);
               state_d   = (iss_cnt_q + LEN_W'(1) == len_q) ? ST_DRAIN : ST_FEED;
            end else begin
               state_d = ST_FEED;
            end
         end
         ST_DRAIN: begin
            // Once the last product has its CEP cycle, wait one more cycle
            // so dsp_P holds the final sum before capturing it.
            if (wait_q) begin
               res_data_d = dsp_P;
               wait_d     = 1'b0;
               state_d    = ST_DONE;
            end else if (acc_cnt_q == len_q) begin
               wait_d = 1'b1;
            end else begin
               wait_d = 1'b0;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      op_ready_d  = (state_d == ST_FEED) && (iss_cnt_d < len_d);
      ce_d        = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      busy_d      = (state_d != ST_IDLE);
      res_valid_d = (state_d == ST_DONE);
   end

   // State and output registers; reset abandons any job in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         len_q       <= {LEN_W{1'b0}};
         iss_cnt_q   <= {LEN_W{1'b0}};
         acc_cnt_q   <= {LEN_W{1'b0}};
         wait_q      <= 1'b0;
         dsp_a_q     <= {A_W{1'b0}};
         dsp_b_q     <= {B_W{1'b0}};
         ce_q        <= 1'b0;
         cep_q       <= 1'b0;
         opmode_q    <= 8'h00;
         op_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= {P_W{1'b0}};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         iss_cnt_q   <= iss_cnt_d;
         acc_cnt_q   <= acc_cnt_d;
         wait_q      <= wait_d;
         dsp_a_q     <= dsp_a_d;
         dsp_b_q     <= dsp_b_d;
         ce_q        <= ce_d;
         cep_q       <= cep_d;
         opmode_q    <= opmode_d;
         op_ready_q  <= op_ready_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign busy       = busy_q;
   assign op_ready   = op_ready_q;
   assign dsp_A      = dsp_a_q;
   assign dsp_B      = dsp_b_q;
   assign dsp_OPMODE = opmode_q;
   assign dsp_CEA    = ce_q;
   assign dsp_CEB    = ce_q;
   assign dsp_CEM    = ce_q;
   assign dsp_CEP    = cep_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice
// (M_LAT-deep product pipeline feeding a 48-bit P register).
// -----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

   localparam int M_LAT = 3;
   localparam int LEN_W = 8;

   logic             CLK;
   logic             RST_N;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             op_valid;
   logic             op_ready;
   logic [17:0]      op_a;
   logic [17:0]      op_b;
   logic [17:0]      dsp_A;
   logic [17:0]      dsp_B;
   logic [7:0]       dsp_OPMODE;
   logic             dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP;
   logic [47:0]      dsp_P;
   logic             res_valid;
   logic             res_ready;
   logic [47:0]      res_data;

   dsp_mac_sequencer #(
      .M_LAT (M_LAT),
      .LEN_W (LEN_W)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .dsp_A      (dsp_A),
      .dsp_B      (dsp_B),
      .dsp_OPMODE (dsp_OPMODE),
      .dsp_CEA    (dsp_CEA),
      .dsp_CEB    (dsp_CEB),
      .dsp_CEM    (dsp_CEM),
      .dsp_CEP    (dsp_CEP),
      .dsp_P      (dsp_P),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural DSP slice: operand present on A/B in cycle k gives its
   // product at the post-adder input in cycle k+M_LAT.
   logic signed [35:0] m_pipe [M_LAT];
   logic        [47:0] p_model;
   assign dsp_P = p_model;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < M_LAT; i++) m_pipe[i] <= 36'sd0;
         p_model <= 48'd0;
      end else begin
         if (dsp_CEA && dsp_CEB && dsp_CEM) begin
            m_pipe[0] <= $signed(dsp_A) * $signed(dsp_B);
            for (int i = 1; i < M_LAT; i++) m_pipe[i] <= m_pipe[i-1];
         end
         if (dsp_CEP) begin
            case (dsp_OPMODE)
               8'h01:   p_model <= {{12{m_pipe[M_LAT-1][35]}}, m_pipe[M_LAT-1]};
               8'h09:   p_model <= p_model + {{12{m_pipe[M_LAT-1][35]}}, m_pipe[M_LAT-1]};
               default: p_model <= p_model;
            endcase
         end
      end
   end

   // Event counters sampled on the active edge (pre-update output values).
   int cep_total = 0;
   int hs_total  = 0;
   always @(posedge CLK) begin
      if (RST_N) begin
         if (dsp_CEP) cep_total++;
         if (res_valid && res_ready) hs_total++;
      end
   end

   typedef struct {
      int                 len;
      int                 gap;
      logic [3:0][17:0]   a;
      logic [3:0][17:0]   b;
      bit                 uniform;
      bit                 pre_reset;
      logic signed [47:0] exp_res;
      int                 exp_cep;
      int                 max_lat;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];
   vec_t cur;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int k, input int n, input int gap,
                          input int a0, input int b0, input int a1, input int b1,
                          input int a2, input int b2, input int a3, input int b3,
                          input bit uni, input bit prst,
                          input logic signed [63:0] exp, input int ncep, input int mlat);
      vecs[k].len       = n;
      vecs[k].gap       = gap;
      vecs[k].a[0]      = 18'(a0);
      vecs[k].b[0]      = 18'(b0);
      vecs[k].a[1]      = 18'(a1);
      vecs[k].b[1]      = 18'(b1);
      vecs[k].a[2]      = 18'(a2);
      vecs[k].b[2]      = 18'(b2);
      vecs[k].a[3]      = 18'(a3);
      vecs[k].b[3]      = 18'(b3);
      vecs[k].uniform   = uni;
      vecs[k].pre_reset = prst;
      vecs[k].exp_res   = exp[47:0];
      vecs[k].exp_cep   = ncep;
      vecs[k].max_lat   = mlat;
   endtask

   task automatic start_job(input int n);
      @(negedge CLK);
      start = 1'b1;
      len   = n[LEN_W-1:0];
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Streams cur's pairs (with cur.gap idle cycles after each accept) until
   // res_valid appears; returns cycles from start acceptance to res_valid.
   task automatic feed_until_result(output int lat);
      int i;
      int gap_cnt;
      int cyc;
      int idx;
      bit got;
      i = 0; gap_cnt = 0; cyc = 1; got = 1'b0;
      while (!got && cyc < 3000) begin
         if (res_valid) begin
            got = 1'b1;
         end else begin
            op_valid = (i < cur.len) && (gap_cnt == 0);
            idx      = (cur.uniform || i > 3) ? 0 : i;
            op_a     = op_valid ? cur.a[idx] : 18'd0;
            op_b     = op_valid ? cur.b[idx] : 18'd0;
            if (op_valid && op_ready) begin
               i++;
               gap_cnt = cur.gap;
            end else if (!op_valid && gap_cnt > 0) begin
               gap_cnt--;
            end
            @(negedge CLK);
            cyc++;
         end
      end
      op_valid = 1'b0;
      op_a     = 18'd0;
      op_b     = 18'd0;
      lat      = cyc;
      check("result_seen", 64'(got), 64'sd1);
   endtask

   task automatic handshake(input string nm);
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      check({nm, "_res_valid_drop"}, 64'(res_valid), 64'sd0);
      check({nm, "_busy_drop"},      64'(busy),      64'sd0);
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_busy"},     64'(busy),      64'sd0);
      check({nm, "_op_ready"}, 64'(op_ready),  64'sd0);
      check({nm, "_res_valid"},64'(res_valid), 64'sd0);
      check({nm, "_res_data"}, 64'(res_data),  64'sd0);
      check({nm, "_dsp_ab"},   64'({dsp_A, dsp_B}), 64'sd0);
      check({nm, "_ce"},       64'({dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP}), 64'sd0);
      check({nm, "_opmode"},   64'(dsp_OPMODE), 64'sd0);
   endtask

   initial begin
      logic signed [63:0] big;
      int lat;
      int cep0;
      int hs0;
      int i;
      int cyc;

      RST_N = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0;
      op_a = 18'd0; op_b = 18'd0; res_ready = 1'b0;

      // len, gap, pairs, uniform, pre_reset, expected, CEP pulses, max latency
      big = 64'sd255 * 64'sd131071 * 64'sd131071;
      set_vec(0, 3, 0, 2, 3, 4, 5, -1, 7, 0, 0, 1'b0, 1'b0, 64'sd19, 3, 0);
      set_vec(1, 3, 2, 2, 3, 4, 5, -1, 7, 0, 0, 1'b0, 1'b0, 64'sd19, 3, 0);
      set_vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 64'sd0, 0, 2);
      set_vec(3, 4, 1, -131072, 131071, 100, -200, 0, 5, -3, -3, 1'b0, 1'b0,
              -64'sd17179758103, 4, 0);
      set_vec(4, 255, 0, 131071, 131071, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0,
              {{16{big[47]}}, big[47:0]}, 255, 0);
      set_vec(5, 2, 0, -131072, -131072, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1,
              64'sd34359738368, 2, 0);

      #3;
      check_all_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // DONE held for 10 cycles: result stable, second start ignored.
      cur = vecs[0];
      cur.len = 2;
      cur.a[0] = 18'd3; cur.b[0] = 18'd4; cur.a[1] = 18'd5; cur.b[1] = 18'd6;
      start_job(2);
      feed_until_result(lat);
      for (int j = 0; j < 10; j++) begin
         start = (j == 3);
         len   = 8'd5;
         check($sformatf("stall%0d_res_data", j), $signed(res_data), 64'sd42);
         check($sformatf("stall%0d_res_valid", j), 64'(res_valid), 64'sd1);
         @(negedge CLK);
      end
      start = 1'b0;
      handshake("stall");
      for (int j = 0; j < 3; j++) begin
         @(negedge CLK);
         check($sformatf("stall_idle%0d_busy", j), 64'(busy), 64'sd0);
      end

      for (int k = 0; k < NVEC; k++) begin
         cur = vecs[k];
         if (cur.pre_reset) begin
            // Abandon a 4-pair job after 2 accepts.
            start_job(4);
            i = 0; cyc = 0;
            while (i < 2 && cyc < 50) begin
               op_valid = 1'b1; op_a = 18'd7; op_b = 18'd7;
               if (op_ready) i++;
               @(negedge CLK);
               cyc++;
            end
            op_valid = 1'b0; op_a = 18'd0; op_b = 18'd0;
            check("midjob_accepts", 64'(i), 64'sd2);
            RST_N = 1'b0;
            #1;
            check_all_zero("midjob_reset");
            @(negedge CLK);
            RST_N = 1'b1;
         end
         cep0 = cep_total;
         hs0  = hs_total;
         start_job(cur.len);
         feed_until_result(lat);
         check($sformatf("v%0d_res_data", k), $signed(res_data), 64'(cur.exp_res));
         check($sformatf("v%0d_busy", k), 64'(busy), 64'sd1);
         if (cur.max_lat > 0) begin
            check($sformatf("v%0d_latency_ok", k), 64'(lat <= cur.max_lat), 64'sd1);
         end
         handshake($sformatf("v%0d", k));
         check($sformatf("v%0d_cep_pulses", k), 64'(cep_total - cep0), 64'(cur.exp_cep));
         check($sformatf("v%0d_handshakes", k), 64'(hs_total - hs0), 64'sd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
